// File: rtl/coriolis_stream_pkg.sv
// Shared constants and the FloPoCo-to-IEEE decode used by the coriolis stream sink.
package coriolis_stream_pkg;

  // FloPoCo exception field encodings
  localparam logic [1:0] FPC_EXC_ZERO = 2'b00;
  localparam logic [1:0] FPC_EXC_NORM = 2'b01;
  localparam logic [1:0] FPC_EXC_INF  = 2'b10;
  localparam logic [1:0] FPC_EXC_NAN  = 2'b11;

  // Canonical quiet NaN emitted for every FloPoCo NaN
  localparam logic [31:0] IEEE_QNAN = 32'h7FC00000;

  // Map a 34-bit FloPoCo word onto IEEE-754 single precision.
  // Zero and infinity keep the sign; NaN collapses to the canonical quiet NaN.
  function automatic logic [31:0] fpc2ieee(input logic [33:0] word);
    logic [31:0] res;
    case (word[33:32])
      FPC_EXC_ZERO: res = {word[31], 31'h00000000};
      FPC_EXC_NORM: res = word[31:0];
      FPC_EXC_INF:  res = {word[31], 8'hFF, 23'h000000};
      FPC_EXC_NAN:  res = IEEE_QNAN;
      default:      res = IEEE_QNAN;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/coriolis_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Besides the registered head it
// publishes head_next, the word that will sit at the head after the coming
// edge, so a consumer can register a function of the head with no extra latency.
module coriolis_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      occupancy,
  output logic [WIDTH-1:0] head_next
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_next;
  logic [AW:0]      remaining;
  logic             push;
  logic             pop;

  assign full      = (cnt == DEPTH_CNT);
  assign empty     = (cnt == (AW+1)'(0));
  assign occupancy = cnt;

  // Handshake qualification, occupancy update and next-head selection
  always_comb begin
    push        = wr_en & ~full;
    pop         = rd_en & ~empty;
    rd_ptr_next = rd_ptr;
    cnt_next    = cnt;
    head_next   = head;
    if (pop) begin
      rd_ptr_next = rd_ptr + AW'(1);
    end else begin
      rd_ptr_next = rd_ptr;
    end
    case ({push, pop})
      2'b10:   cnt_next = cnt + (AW+1)'(1);
      2'b01:   cnt_next = cnt - (AW+1)'(1);
      default: cnt_next = cnt;
    endcase
    // Words still stored once the current pop is taken; if none, the
    // incoming word (when there is one) becomes the head directly.
    remaining = cnt - (AW+1)'(pop);
    if (remaining == (AW+1)'(0)) begin
      if (push) begin
        head_next = wdata;
      end else begin
        head_next = head;
      end
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      cnt    <= (AW+1)'(0);
      head   <= WIDTH'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_next;
      cnt    <= cnt_next;
      head   <= head_next;
    end
  end

endmodule

// File: rtl/coriolis_stream_sink.sv
// Terminal consumer of a coriolis leaf stream: buffers FloPoCo words, decodes
// them to IEEE-754 single, counts delivered elements and flags completion and
// non-normal results.
module coriolis_stream_sink
  import coriolis_stream_pkg::*;
#(
  parameter int STREAMW = 34,
  parameter int DATAW   = 32,
  parameter int FIFO_AW = 3,
  parameter int NELEM   = 1024,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  output logic               iready,
  output logic               ovalid,
  output logic [DATAW-1:0]   out1,
  input  logic               oready,
  output logic [CNTW-1:0]    count,
  output logic               done,
  output logic               exc_seen
);

  localparam logic [CNTW-1:0] NELEM_CNT = CNTW'(NELEM);

  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   occupancy;
  logic [STREAMW-1:0] head_next;
  logic [1:0]         head_exc;
  logic               push_req;
  logic               xfer;

  // iready depends only on state (and reset), never on oready or ivalid_in1
  assign iready   = rst & ~fifo_full & ~done;
  assign push_req = ivalid_in1 & iready;
  assign ovalid   = (occupancy != {(FIFO_AW+1){1'b0}});
  assign xfer     = oready & ~fifo_empty;

  coriolis_sync_fifo #(
    .WIDTH (STREAMW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push_req),
    .wdata     (in1),
    .rd_en     (oready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy),
    .head_next (head_next)
  );

  // Decoded output register, head exception tag, element counter and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      out1     <= {DATAW{1'b0}};
      head_exc <= FPC_EXC_ZERO;
      count    <= {CNTW{1'b0}};
      done     <= 1'b0;
      exc_seen <= 1'b0;
    end else begin
      out1     <= fpc2ieee(head_next);
      head_exc <= head_next[STREAMW-1 -: 2];
      if (xfer && !done) begin
        count <= count + CNTW'(1);
        if ((count + CNTW'(1)) == NELEM_CNT) begin
          done <= 1'b1;
        end
      end
      if (xfer && (head_exc != FPC_EXC_NORM)) begin
        exc_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coriolis_stream_sink.sv
// Self-checking bench for coriolis_stream_sink: a queue-based transaction model
// checks every cycle, plus a decode table and directed multi-cycle sequences.
module tb_coriolis_stream_sink;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance (NELEM = 1024)
  logic        ivalid_in1 = 1'b0;
  logic [33:0] in1 = 34'h0;
  logic        oready = 1'b0;
  logic        iready, ovalid, done, exc_seen;
  logic [31:0] out1;
  logic [15:0] count;

  // Small instance used for the completion sequence (NELEM = 4)
  logic        s_ivalid = 1'b0;
  logic [33:0] s_in1 = 34'h0;
  logic        s_oready = 1'b0;
  logic        s_iready, s_ovalid, s_done, s_exc_seen;
  logic [31:0] s_out1;
  logic [15:0] s_count;

  coriolis_stream_sink dut (
    .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .iready(iready),
    .ovalid(ovalid), .out1(out1), .oready(oready), .count(count), .done(done),
    .exc_seen(exc_seen)
  );

  coriolis_stream_sink #(.NELEM(4)) dut_small (
    .clk(clk), .rst(rst), .ivalid_in1(s_ivalid), .in1(s_in1), .iready(s_iready),
    .ovalid(s_ovalid), .out1(s_out1), .oready(s_oready), .count(s_count), .done(s_done),
    .exc_seen(s_exc_seen)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of words, counters are plain ints
  localparam int NELEM_MAIN = 1024;
  localparam int DEPTH      = 8;
  logic [33:0] mq[$];
  int          m_count = 0;
  bit          m_done  = 1'b0;
  bit          m_exc   = 1'b0;

  function automatic logic [31:0] ref_decode(input logic [33:0] w);
    logic [31:0] sign_bit;
    sign_bit = w[31] ? 32'h80000000 : 32'h00000000;
    if (w[33:32] == 2'b01)      return w[31:0];
    else if (w[33:32] == 2'b00) return sign_bit;
    else if (w[33:32] == 2'b10) return sign_bit + 32'h7F800000;
    else                        return 32'h7FC00000;
  endfunction

  // One clock cycle on the main instance: drive, compare against the model, advance
  task automatic step(input logic iv, input logic [33:0] w, input logic ordy,
                      output logic acc_in, output logic acc_out, output logic [31:0] seen);
    bit exp_ir, exp_ov, m_in, m_out;
    ivalid_in1 = iv;
    in1        = w;
    oready     = ordy;
    #1;
    exp_ir = (mq.size() < DEPTH) && !m_done;
    exp_ov = (mq.size() > 0);
    chk("iready", 64'(iready), 64'(exp_ir));
    chk("ovalid", 64'(ovalid), 64'(exp_ov));
    if (exp_ov) chk("out1", 64'(out1), 64'(ref_decode(mq[0])));
    chk("count", 64'(count), 64'(m_count));
    chk("done", 64'(done), 64'(m_done));
    chk("exc_seen", 64'(exc_seen), 64'(m_exc));
    acc_in  = iv & iready;
    acc_out = ovalid & ordy;
    seen    = out1;
    m_in  = iv && exp_ir;
    m_out = ordy && exp_ov;
    @(posedge clk);
    if (m_out) begin
      if (!m_done) m_count++;
      if (m_count == NELEM_MAIN) m_done = 1'b1;
      if (mq[0][33:32] != 2'b01) m_exc = 1'b1;
      void'(mq.pop_front());
    end
    if (m_in) mq.push_back(w);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ivalid_in1 = 1'b0; in1 = 34'h0; oready = 1'b0;
    s_ivalid = 1'b0; s_in1 = 34'h0; s_oready = 1'b0;
    #1;
    chk("rst_iready_low", 64'(iready), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_ovalid", 64'(ovalid), 64'(0));
    chk("rst_out1", 64'(out1), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_exc_seen", 64'(exc_seen), 64'(0));
    chk("rst_occupancy", 64'(dut.u_fifo.occupancy), 64'(0));
    chk("rst_small_count", 64'(s_count), 64'(0));
    chk("rst_small_done", 64'(s_done), 64'(0));
    rst = 1'b1;
    mq.delete();
    m_count = 0; m_done = 1'b0; m_exc = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [33:0] word;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ai, ao;
    logic [31:0] seen;
    int          idx;
    int          acc;
    int          exp_cnt;
    logic [31:0] got[$];
    logic [1:0]  e;

    tbl[0] = '{{2'b01, 32'h3F800000}, 32'h3F800000};
    tbl[1] = '{{2'b00, 32'hBF800000}, 32'h80000000};
    tbl[2] = '{{2'b10, 32'h80000000}, 32'hFF800000};
    tbl[3] = '{{2'b11, 32'h12345678}, 32'h7FC00000};
    tbl[4] = '{{2'b00, 32'h3F800000}, 32'h00000000};
    tbl[5] = '{{2'b10, 32'h7F123456}, 32'h7F800000};
    tbl[6] = '{{2'b01, 32'hC0490FDB}, 32'hC0490FDB};
    tbl[7] = '{{2'b11, 32'hFFFFFFFF}, 32'h7FC00000};

    do_reset();

    // Normal decode with 1-cycle latency
    step(1'b1, {2'b01, 32'h3F800000}, 1'b1, ai, ao, seen);
    chk("t1_accept", 64'(ai), 64'(1));
    chk("t1_ovalid", 64'(ovalid), 64'(1));
    chk("t1_out1", 64'(out1), 64'(32'h3F800000));
    step(1'b0, 34'h0, 1'b1, ai, ao, seen);
    chk("t1_count", 64'(count), 64'(1));
    chk("t1_exc_seen", 64'(exc_seen), 64'(0));
    chk("t1_drained", 64'(ovalid), 64'(0));

    // Exception words back to back
    step(1'b1, {2'b00, 32'hBF800000}, 1'b1, ai, ao, seen);
    chk("t2_out_zero", 64'(out1), 64'(32'h80000000));
    chk("t2_exc_before", 64'(exc_seen), 64'(0));
    step(1'b1, {2'b10, 32'h80000000}, 1'b1, ai, ao, seen);
    chk("t2_out_inf", 64'(out1), 64'(32'hFF800000));
    chk("t2_exc_after", 64'(exc_seen), 64'(1));
    step(1'b1, {2'b11, 32'h12345678}, 1'b1, ai, ao, seen);
    chk("t2_out_nan", 64'(out1), 64'(32'h7FC00000));
    step(1'b0, 34'h0, 1'b1, ai, ao, seen);
    chk("t2_count", 64'(count), 64'(4));

    // Decode table, one word at a time into an empty FIFO
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].word, 1'b1, ai, ao, seen);
      chk("tbl_ovalid", 64'(ovalid), 64'(1));
      chk("tbl_out1", 64'(out1), 64'(tbl[i].exp));
      step(1'b0, 34'h0, 1'b1, ai, ao, seen);
    end
    chk("tbl_count", 64'(count), 64'(12));

    // Backpressure: fill, hold, release
    do_reset();
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      step(idx <= 10, {2'b01, 32'(idx)}, 1'b0, ai, ao, seen);
      if (ai) idx++;
    end
    chk("bp_accepted", 64'(idx - 1), 64'(8));
    chk("bp_iready_full", 64'(iready), 64'(0));
    chk("bp_ovalid", 64'(ovalid), 64'(1));
    chk("bp_out1_stable", 64'(out1), 64'(1));
    chk("bp_occupancy", 64'(dut.u_fifo.occupancy), 64'(8));
    got.delete();
    step(idx <= 10, {2'b01, 32'(idx)}, 1'b1, ai, ao, seen);
    chk("bp_no_push_when_full", 64'(ai), 64'(0));
    if (ao) got.push_back(seen);
    chk("bp_iready_rises", 64'(iready), 64'(1));
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      step(idx <= 10, {2'b01, 32'(idx)}, 1'b1, ai, ao, seen);
      if (ai) idx++;
      if (ao) got.push_back(seen);
    end
    chk("bp_total", 64'(got.size()), 64'(10));
    for (int i = 0; i < got.size(); i++) chk("bp_order", 64'(got[i]), 64'(i + 1));

    // Concurrent push and pop at occupancy 4
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, {2'b01, 32'(100 + i)}, 1'b0, ai, ao, seen);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, {2'b01, 32'(200 + c)}, 1'b1, ai, ao, seen);
      chk("cc_occupancy", 64'(dut.u_fifo.occupancy), 64'(4));
      chk("cc_ovalid", 64'(ovalid), 64'(1));
    end
    for (int c = 0; c < 5; c++) step(1'b0, 34'h0, 1'b1, ai, ao, seen);
    chk("cc_drained", 64'(ovalid), 64'(0));

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      e = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), {e, 32'($urandom())},
           ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 7 : 3)), ai, ao, seen);
    end

    // Reset mid-run with 5 words buffered
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, {2'b01, 32'(300 + i)}, 1'b0, ai, ao, seen);
    chk("mr_occupancy", 64'(dut.u_fifo.occupancy), 64'(5));
    do_reset();
    step(1'b1, {2'b01, 32'h40490FDB}, 1'b1, ai, ao, seen);
    chk("mr_fresh_ovalid", 64'(ovalid), 64'(1));
    chk("mr_fresh_out1", 64'(out1), 64'(32'h40490FDB));
    step(1'b0, 34'h0, 1'b1, ai, ao, seen);
    chk("mr_no_stale", 64'(ovalid), 64'(0));
    chk("mr_count", 64'(count), 64'(1));

    // Completion on the NELEM=4 instance: offer 6 words
    idx = 1; acc = 0; exp_cnt = 0;
    got.delete();
    for (int c = 0; c < 14; c++) begin
      s_ivalid = (idx <= 6);
      s_in1    = {2'b01, 32'(idx)};
      s_oready = 1'b1;
      #1;
      chk("cp_count", 64'(s_count), 64'(exp_cnt));
      chk("cp_done", 64'(s_done), 64'(exp_cnt == 4));
      if (exp_cnt == 4) chk("cp_iready_after_done", 64'(s_iready), 64'(0));
      if (s_ovalid && s_oready) begin
        got.push_back(s_out1);
        if (exp_cnt < 4) exp_cnt++;
      end
      if (s_ivalid && s_iready) begin
        acc++;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    s_ivalid = 1'b0;
    chk("cp_accepted", 64'(acc), 64'(5));
    chk("cp_delivered", 64'(got.size()), 64'(5));
    for (int i = 0; i < got.size(); i++) chk("cp_order", 64'(got[i]), 64'(i + 1));
    chk("cp_final_count", 64'(s_count), 64'(4));
    chk("cp_final_done", 64'(s_done), 64'(1));
    chk("cp_final_iready", 64'(s_iready), 64'(0));
    chk("cp_final_ovalid", 64'(s_ovalid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coriolis_stream_sink.md
Name: coriolis_stream_sink

Overview:
Terminal consumer for the output stream of a coriolis kernel leaf node. It accepts 34-bit FloPoCo-format words (2-bit exception field plus 32-bit sign/exp/mantissa) over a valid/ready handshake and buffers them in a small FIFO. Each word is decoded back to plain IEEE-754 single precision and presented to the downstream host or memory writer. It counts delivered elements and flags completion and any non-normal results.

Parameters:
STREAMW, 34, input word width (exception field + 32-bit float)
DATAW, 32, output word width (IEEE-754 single)
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW = 8
NELEM, 1024, elements per run; done fires after NELEM output transfers
CNTW, 16, element counter width; must hold NELEM

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (0 = reset)
ivalid_in1  input  1  upstream word valid
in1  input  STREAMW  upstream FloPoCo word: [33:32] exception, [31] sign, [30:0] exp/mantissa
iready  output  1  sink can accept a word this cycle
ovalid  output  1  decoded word valid
out1  output  DATAW  decoded IEEE-754 word
oready  input  1  downstream accepts out1
count  output  CNTW  output transfers completed
done  output  1  count has reached NELEM (sticky)
exc_seen  output  1  sticky; a non-normal word (exception field != 01) has been delivered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low. All state is reset on a clk edge with rst=0.
- Reset values: iready=0 while rst=0, ovalid=0, out1=0, count=0, done=0, exc_seen=0, FIFO empty.
- Input transfer: occurs when ivalid_in1 & iready. iready = !fifo_full & !done. iready has no combinational path from oready or ivalid_in1.
- Full boundary:
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - When the FIFO becomes non-full, iready rises on the next cycle.
- FIFO behaviour:
  - First-word-fall-through, registered output.
  - A word pushed into an empty FIFO at edge t is visible on ovalid/out1 after edge t. Latency is 1 cycle.
  - Simultaneous push and pop when neither full nor empty: both occur, occupancy is unchanged.
  - Pointers wrap modulo 2^FIFO_AW. Occupancy is held in an FIFO_AW+1 bit counter.
- Output transfer: occurs when ovalid & oready. While ovalid & !oready, out1 holds stable. ovalid never drops without a transfer.
- Decode is combinational on the FIFO head and registered into out1. Let s = head[31]:
  - exc=00 (zero): out1 = {s, 31'h0}
  - exc=01 (normal): out1 = head[31:0]
  - exc=10 (infinity): out1 = {s, 8'hFF, 23'h0}
  - exc=11 (NaN): out1 = 32'h7FC00000
- exc_seen: set when a word with exc != 01 completes an output transfer.
- count:
  - Increments on each output transfer and saturates at NELEM.
  - done is set in the same edge that count reaches NELEM.
  - After done, iready=0. Residual FIFO contents still drain, but count does not advance past NELEM.
- Reset mid-operation: FIFO contents are discarded, pointers are zeroed, and all outputs return to reset values on that edge. No partial transfer survives.

Decomposition:
- Package coriolis_stream_pkg holds:
  - FPC_EXC_ZERO=2'b00, FPC_EXC_NORM=2'b01, FPC_EXC_INF=2'b10, FPC_EXC_NAN=2'b11
  - IEEE_QNAN=32'h7FC00000
  - the fpc2ieee decode function
- Sub-module coriolis_sync_fifo:
  - parameterised on width and FIFO_AW
  - first-word-fall-through, synchronous active-low reset
  - exposes full, empty and occupancy
- Top level holds the decode, output register, counter and flags.

Test Plan:
- Normal decode: after reset, oready=1, push in1={2'b01,32'h3F800000} -> iready=1 throughout; next cycle ovalid=1, out1=32'h3F800000; count=1, exc_seen=0.
- Exception decode: push {2'b00,32'hBF800000}, then {2'b10,32'h80000000}, then {2'b11,32'h12345678} -> out1 is 32'h80000000, 32'hFF800000, 32'h7FC00000 on consecutive cycles; exc_seen=1 after the first of these.
- Backpressure and full:
  - Hold oready=0 and stream 10 words 1..10 -> iready drops after word 8 is accepted; word 9 is held by upstream; out1=1 stays stable.
  - Release oready -> words 1..10 arrive in order with no loss or duplication.
  - iready rises the cycle after the first pop.
- Concurrent push and pop: with occupancy 4, hold ivalid_in1=1 and oready=1 for 20 cycles -> occupancy stays at 4 and ovalid stays at 1.
- Completion: NELEM=4, push 6 words -> iready=0 once done rises at the 4th output transfer; count=4 and saturated; done stays 1.
- Reset mid-run: with 5 words buffered, drive rst=0 for one edge -> ovalid=0, count=0, done=0, exc_seen=0, FIFO empty. A fresh push after reset yields a correct 1-cycle latency.
